imem_dmem_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage MIPS pipeline.
- Serialises requests, sequences each access against a fixed-latency memory, and returns data with a one-cycle ack pulse.
- Requesters hold their request until ack, so the pipeline stalls while an access is outstanding.

---
 rtl/imem_dmem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Purpose:
//   Shares one single-port unified memory between the instruction-fetch (IF)
//   and data-memory (MEM) stages of a 5-stage MIPS pipeline. It serialises
//   requests and runs each access through IDLE -> ISSUE -> WAIT -> DONE
//   against a fixed-latency memory. It returns read data together with a
//   one-cycle ack pulse to the requester that won arbitration.
//
// Optional feature (compile-time macro ARB_FAIR_EN):
//   When ARB_FAIR_EN is defined, a last-grant flag alternates priority if
//   both requesters collide in IDLE. After a DM grant, IF wins the next
//   collision. When ARB_FAIR_EN is undefined, DM always wins.
//
// Parameters:
//   ADDR_W  - address width
//   DATA_W  - data width
//   MEM_LAT - cycles from mem_en to valid mem_rdata (1..15)
//
// Ports:
//   clk, rst_n            - rising-edge clock, synchronous active-low reset
//   if_req/if_addr        - IF read request (held until if_ack) and PC
//   if_rdata/if_ack       - fetched instruction and one-cycle completion
//   dm_req/dm_we          - MEM request (held until dm_ack), 1 = store
//   dm_addr/dm_wdata      - data address and store data
//   dm_rdata/dm_ack       - load data and one-cycle completion
//   mem_en/mem_we         - memory strobe (one cycle) and write enable
//   mem_addr/mem_wdata    - memory address and write data
//   mem_rdata             - memory read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem    - combinational req & ~ack stall indications
// ---------------------------------------------------------------------------
module imem_dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The counter is loaded with MEM_LAT-1 so that the last WAIT cycle
    // (count 0) coincides with the cycle in which mem_rdata is valid.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    logic [1:0]        state_r;
    logic [3:0]        cnt_r;
    logic              grant_dm_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              if_ack_r;
    logic              dm_ack_r;
    logic              pick_dm_s;

`ifdef ARB_FAIR_EN
    logic              last_dm_r;

    // Last-grant flag: remembers whether the access just completed was DM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_dm_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            last_dm_r <= grant_dm_r;
        end else begin
            last_dm_r <= last_dm_r;
        end
    end

    // Winner selection: on a collision, IF wins only if DM had the last grant.
    always_comb begin
        pick_dm_s = 1'b0;
        if (dm_req && if_req) begin
            pick_dm_s = ~last_dm_r;
        end else begin
            pick_dm_s = dm_req;
        end
    end
`else
    // Winner selection: DM (the older instruction) always wins a collision.
    always_comb begin
        pick_dm_s = 1'b0;
        if (dm_req) begin
            pick_dm_s = 1'b1;
        end else begin
            pick_dm_s = 1'b0;
        end
    end
`endif

    // Access sequencer: arbitration, memory strobe, latency count, capture and ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            grant_dm_r  <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            mem_en_r <= 1'b0;
            if_ack_r <= 1'b0;
            dm_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (if_req || dm_req) begin
                        grant_dm_r <= pick_dm_s;
                        mem_en_r   <= 1'b1;
                        state_r    <= ST_ISSUE;
                        if (pick_dm_s) begin
                            mem_addr_r  <= dm_addr;
                            mem_we_r    <= dm_we;
                            mem_wdata_r <= dm_wdata;
                        end else begin
                            mem_addr_r  <= if_addr;
                            mem_we_r    <= 1'b0;
                            mem_wdata_r <= '0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= LAT_LOAD;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_DONE;
                        if (grant_dm_r) begin
                            dm_ack_r <= 1'b1;
                            // Stores leave the previous load data untouched.
                            if (!mem_we_r) begin
                                dm_rdata_r <= mem_rdata;
                            end else begin
                                dm_rdata_r <= dm_rdata_r;
                            end
                        end else begin
                            if_ack_r   <= 1'b1;
                            if_rdata_r <= mem_rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Requests seen here are ignored; they are re-sampled in IDLE.
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_r;
    assign if_ack    = if_ack_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_ack    = dm_ack_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign stall_if  = if_req & ~if_ack_r;
    assign stall_mem = dm_req & ~dm_ack_r;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_dmem_arbiter
//
// Self-checking bench for imem_dmem_arbiter. A behavioural fixed-latency
// memory answers the DUT. Stimulus pushes the expected memory operations and
// acks (cycle, port, data) into scoreboard queues. A negedge monitor pops the
// queues and compares them against what the DUT produces.
// ---------------------------------------------------------------------------
module tb_imem_dmem_arbiter;

    parameter int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Cycle counter: value seen after a posedge names the cycle that edge opens.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural memory with MEM_LAT read latency ----------
    logic [31:0] mem_arr [0:255];
    logic        pv [MEM_LAT];
    logic [31:0] pd [MEM_LAT];

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
        mem_arr[16] = 32'h8C08_0004;
        for (int i = 0; i < MEM_LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = 32'h0;
        end
    end

    // Memory model: writes on the strobe edge, read data appears MEM_LAT cycles later.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
        pv[0] <= mem_en && !mem_we;
        pd[0] <= mem_arr[mem_addr[9:2]];
        for (int i = 1; i < MEM_LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mem_rdata = pv[MEM_LAT-1] ? pd[MEM_LAT-1] : 32'hBAD0_BAD0;

    // ---------------- scoreboard ----------------------------------------------
    typedef struct { bit dm; int cyc; logic [31:0] data; } ack_exp_t;
    typedef struct { bit we; int cyc; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
    ack_exp_t ack_q[$];
    mem_exp_t mem_q[$];
    logic     prev_en = 1'b0;

    task automatic expect_access(input bit dm, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] data,
                                 input int wait_cyc, input bit with_ack);
        mem_exp_t m;
        ack_exp_t a;
        m.we = we; m.cyc = cyc + 1 + wait_cyc; m.addr = addr; m.wdata = wdata;
        mem_q.push_back(m);
        if (with_ack) begin
            a.dm = dm; a.cyc = cyc + 2 + MEM_LAT + wait_cyc; a.data = data;
            ack_q.push_back(a);
        end
    endtask

    // Monitor: compares every memory strobe and ack against the scoreboard.
    always @(negedge clk) begin
        mem_exp_t m;
        ack_exp_t a;
        if (mem_en) begin
            check_eq("mem_en_width", {31'd0, prev_en}, 32'd0);
            if (mem_q.size() == 0) begin
                check_eq("unexpected_mem_en", 32'd1, 32'd0);
            end else begin
                m = mem_q.pop_front();
                check_eq("mem_en_cycle", cyc, m.cyc);
                check_eq("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                check_eq("mem_addr", mem_addr, m.addr);
                if (m.we) check_eq("mem_wdata", mem_wdata, m.wdata);
            end
        end
        prev_en <= mem_en;
        if (if_ack || dm_ack) begin
            check_eq("ack_exclusive", {31'd0, if_ack & dm_ack}, 32'd0);
            if (ack_q.size() == 0) begin
                check_eq("unexpected_ack", 32'd1, 32'd0);
            end else begin
                a = ack_q.pop_front();
                check_eq("ack_port_dm", {31'd0, dm_ack}, {31'd0, a.dm});
                check_eq("ack_cycle", cyc, a.cyc);
                if (a.dm) check_eq("dm_rdata", dm_rdata, a.data);
                else      check_eq("if_rdata", if_rdata, a.data);
            end
        end
    end

    // ---------------- requester tasks -----------------------------------------
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if_ack;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ack && n < 200);
        if (!if_ack) check_eq("if_ack_timeout", 32'd0, 32'd1);
        next_cycle();
        if_req = 1'b0;
    endtask

    task automatic wait_dm_ack;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_ack && n < 200);
        if (!dm_ack) check_eq("dm_ack_timeout", 32'd0, 32'd1);
        next_cycle();
        dm_req = 1'b0;
    endtask

    task automatic if_access(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
        wait_if_ack();
    endtask

    task automatic dm_access(input bit we, input logic [31:0] a, input logic [31:0] wd);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        wait_dm_ack();
    endtask

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ------------------------------------------------
    initial begin
        logic [31:0] exp_dm_rdata;
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        exp_dm_rdata = 32'h0;

        // Reset held 3 cycles with a pending fetch: everything stays quiet.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_mem_en", {31'd0, mem_en}, 32'd0);
            check_eq("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
            check_eq("rst_if_rdata", if_rdata, 32'd0);
            check_eq("rst_dm_rdata", dm_rdata, 32'd0);
            check_eq("rst_mem_addr", mem_addr, 32'd0);
            check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        end
        next_cycle();
        // Release in cycle 0: strobe in cycle 1, ack in cycle 2+MEM_LAT.
        expect_access(1'b0, 1'b0, 32'h0, 32'h0, init_word(0), 0, 1'b1);
        rst_n = 1'b1;
        wait_if_ack();

        // IF read from 0x40 with stall_if observed every cycle.
        expect_access(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C08_0004, 0, 1'b1);
        if_addr = 32'h40;
        if_req  = 1'b1;
        for (int k = 0; k <= 2 + MEM_LAT; k++) begin
            @(negedge clk);
            check_eq("stall_if", {31'd0, stall_if}, {31'd0, (k < 2 + MEM_LAT)});
        end
        next_cycle();
        if_req = 1'b0;

        // Store then load of the same word.
        expect_access(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, exp_dm_rdata, 0, 1'b1);
        dm_access(1'b1, 32'h100, 32'hDEAD_BEEF);
        check_eq("if_rdata_hold", if_rdata, 32'h8C08_0004);
        exp_dm_rdata = 32'hDEAD_BEEF;
        expect_access(1'b1, 1'b0, 32'h100, 32'h0, exp_dm_rdata, 0, 1'b1);
        dm_access(1'b0, 32'h100, 32'h0);

        // Collision right after a DM grant.
`ifdef ARB_FAIR_EN
        expect_access(1'b0, 1'b0, 32'h44, 32'h0, init_word(17), 0, 1'b1);
        expect_access(1'b1, 1'b0, 32'h100, 32'h0, exp_dm_rdata, MEM_LAT + 3, 1'b1);
`else
        expect_access(1'b1, 1'b0, 32'h100, 32'h0, exp_dm_rdata, 0, 1'b1);
        expect_access(1'b0, 1'b0, 32'h44, 32'h0, init_word(17), MEM_LAT + 3, 1'b1);
`endif
        fork
            dm_access(1'b0, 32'h100, 32'h0);
            if_access(32'h44);
        join

        // Reset in the first WAIT cycle: the access is abandoned without ack.
        expect_access(1'b1, 1'b0, 32'h104, 32'h0, 32'h0, 0, 1'b0);
        dm_we = 1'b0; dm_addr = 32'h104; dm_req = 1'b1;
        next_cycle();
        next_cycle();
        rst_n  = 1'b0;
        dm_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_mid_no_ack", {30'd0, if_ack, dm_ack}, 32'd0);
            next_cycle();
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_mid_quiet", {29'd0, if_ack, dm_ack, mem_en}, 32'd0);
            next_cycle();
        end

        // Fresh request after reset has the full latency, then back-to-back fetches.
        expect_access(1'b0, 1'b0, 32'h48, 32'h0, init_word(18), 0, 1'b1);
        if_access(32'h48);
        expect_access(1'b0, 1'b0, 32'h4C, 32'h0, init_word(19), 0, 1'b1);
        if_access(32'h4C);
        expect_access(1'b0, 1'b0, 32'h50, 32'h0, init_word(20), 0, 1'b1);
        if_access(32'h50);
        check_eq("dm_rdata_hold", dm_rdata, 32'h0);

        repeat (MEM_LAT + 4) next_cycle();
        check_eq("sb_ack_empty", ack_q.size(), 32'd0);
        check_eq("sb_mem_empty", mem_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
